// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTING,
    HALTED
  } fetch_state_t;

  localparam int PC_INC     = 4;
  localparam int PC_W_DEF   = 10;
  localparam int INST_W_DEF = 32;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} holding buffer for fetch-to-decode stalls.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [INST_W-1:0] load_inst,
  input  logic [PC_W-1:0]   load_pc,
  output logic              vld,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      inst <= '0;
      pc   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      inst <= load_inst;
      pc   <= load_pc;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC, 1-cycle imem sequencing, skid, halt/resume.
// Define FETCH_PERF_CNT_EN for stall/flush counters.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              halt_req,
  input  logic              resume_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  fetch_state_t      state;
  logic [PC_W-1:0]   pc_q;
  logic              rd_vld_q;
  logic [PC_W-1:0]   rd_pc_q;
  logic              skid_vld;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_pc;
  logic              issue;

  assign issue = (state == RUN) &&
                 (flush || !stall || (!skid_vld && !rd_vld_q));

  assign imem_addr = flush ? flush_pc : pc_q;

  assign inst_valid = !flush && (skid_vld || rd_vld_q);

  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (skid_vld) begin
      inst    = skid_inst;
      inst_pc = skid_pc;
    end else if (rd_vld_q) begin
      inst    = imem_data;
      inst_pc = rd_pc_q;
    end
  end

  fetch_skid_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (rd_vld_q && stall && !flush),
    .drain     (!stall),
    .clear     (flush),
    .load_inst (imem_data),
    .load_pc   (rd_pc_q),
    .vld       (skid_vld),
    .inst      (skid_inst),
    .pc        (skid_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      rd_vld_q <= 1'b0;
      rd_pc_q  <= '0;
      halted   <= 1'b0;
    end else begin
      rd_vld_q <= issue;
      if (issue) begin
        rd_pc_q <= imem_addr;
        pc_q    <= imem_addr + PC_W'(PC_INC);
      end else if (flush) begin
        pc_q <= flush_pc;
      end
      unique case (state)
        BOOT: state <= RUN;
        RUN: if (halt_req) state <= HALTING;
        HALTING:
          if (!rd_vld_q && !skid_vld) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        HALTED:
          if (resume_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (inst_valid && stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != '1)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

  // skid only fills from a live read, and a full skid blocks issue
  assert property (@(posedge clk) disable iff (!rst)
    !(skid_vld && rd_vld_q));

endmodule
